// File: rtl/sc_q_update_scheduler.sv
// Sequences one stochastic-computing Q-value update per request:
// read Q(addr), load the SNG operands, run the bitstream evaluation window,
// accumulate the datapath ones-count, write back the saturated result and
// return it over a valid/ready response channel.
module sc_q_update_scheduler #(
    parameter int N                = 8,
    parameter int BITSTREAM_LENGTH = 256,
    parameter int ADDR_W           = 6,
    parameter int DP_LAT           = 1
) (
    input  logic              clk,
    input  logic              reset,
    // request channel from the RL agent
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [N-1:0]      req_q_prime,
    input  logic [N-1:0]      req_reward,
    input  logic [N-1:0]      alpha_cfg,
    input  logic [N-1:0]      gamma_cfg,
    // Q-table RAM (synchronous read, data valid the cycle after mem_rd_en)
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_rd_data,
    output logic [N-1:0]      mem_wr_data,
    // SC datapath
    output logic              sng_load,
    output logic              sng_en,
    output logic [N-1:0]      sng_q,
    output logic [N-1:0]      sng_q_prime,
    output logic [N-1:0]      sng_reward,
    output logic [N-1:0]      sng_alpha,
    output logic [N-1:0]      sng_gamma,
    input  logic [1:0]        dp_out,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [N-1:0]      rsp_q_new,
    output logic              busy
);

    localparam int ACC_W      = N + 2;
    localparam int RUN_CYCLES = BITSTREAM_LENGTH + DP_LAT;
    localparam int CNT_W      = $clog2(RUN_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_EN_END   = CNT_W'(BITSTREAM_LENGTH);
    localparam logic [CNT_W-1:0] C_ACC_LO   = CNT_W'(DP_LAT);
    localparam logic [CNT_W-1:0] C_ACC_HI   = CNT_W'(DP_LAT + BITSTREAM_LENGTH);
    localparam logic [ACC_W-1:0] C_Q_MAX    = {2'b00, {N{1'b1}}};

    // Elaboration-time parameter sanity checks.
    if (BITSTREAM_LENGTH != (1 << N)) begin : g_len_check
        $fatal(1, "BITSTREAM_LENGTH must equal 2**N");
    end
    if (DP_LAT < 0 || DP_LAT > 7) begin : g_lat_check
        $fatal(1, "DP_LAT must be in 0..7");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOAD,
        S_RUN,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [N-1:0]      r_q_prime;
    logic [N-1:0]      r_reward;
    logic [N-1:0]      r_alpha;
    logic [N-1:0]      r_gamma;

    logic [N-1:0]      r_sng_q;
    logic [N-1:0]      r_sng_q_prime;
    logic [N-1:0]      r_sng_reward;
    logic [N-1:0]      r_sng_alpha;
    logic [N-1:0]      r_sng_gamma;

    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [N-1:0]      r_rsp_q_new;

    logic              w_accept;
    logic              w_acc_window;
    logic [N-1:0]      w_q_sat;

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic and control strobes, all decoded from the current state.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        sng_load     = 1'b0;
        sng_en       = 1'b0;
        rsp_valid    = 1'b0;
        w_acc_window = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = S_READ;
            end
            S_READ: begin
                mem_rd_en    = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: w_state_next = S_LOAD;
            S_LOAD: begin
                sng_load     = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                sng_en       = (r_cnt < C_EN_END);
                w_acc_window = (r_cnt >= C_ACC_LO) && (r_cnt < C_ACC_HI);
                if (r_cnt == C_RUN_LAST) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en    = 1'b1;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept = req_valid && req_ready;
    assign w_q_sat  = (r_acc > C_Q_MAX) ? {N{1'b1}} : r_acc[N-1:0];

    // Capture the request on accept; later input changes are ignored.
    // NOTE: reset clears every register, including data, so an aborted
    // update leaves no stale operands or addresses on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_q_prime <= '0;
            r_reward  <= '0;
            r_alpha   <= '0;
            r_gamma   <= '0;
        end else if (w_accept) begin
            r_addr    <= req_addr;
            r_q_prime <= req_q_prime;
            r_reward  <= req_reward;
            r_alpha   <= alpha_cfg;
            r_gamma   <= gamma_cfg;
        end
    end

    // Operand registers: RAM data is valid during WAIT, so the operands are
    // registered on the WAIT->LOAD edge and are stable for the whole
    // sng_load pulse and until the next LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sng_q       <= '0;
            r_sng_q_prime <= '0;
            r_sng_reward  <= '0;
            r_sng_alpha   <= '0;
            r_sng_gamma   <= '0;
        end else if (r_state == S_WAIT) begin
            r_sng_q       <= mem_rd_data;
            r_sng_q_prime <= r_q_prime;
            r_sng_reward  <= r_reward;
            r_sng_alpha   <= r_alpha;
            r_sng_gamma   <= r_gamma;
        end
    end

    // RUN cycle counter and ones-count accumulator; both cleared in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == S_LOAD) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_acc_window) r_acc <= r_acc + {{N{1'b0}}, dp_out};
        end
    end

    // Response registers, loaded in WRITE with the value written to the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_addr  <= '0;
            r_rsp_q_new <= '0;
        end else if (r_state == S_WRITE) begin
            r_rsp_addr  <= r_addr;
            r_rsp_q_new <= w_q_sat;
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wr_data = w_q_sat;
    assign sng_q       = r_sng_q;
    assign sng_q_prime = r_sng_q_prime;
    assign sng_reward  = r_sng_reward;
    assign sng_alpha   = r_sng_alpha;
    assign sng_gamma   = r_sng_gamma;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_q_new   = r_rsp_q_new;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sc_q_update_scheduler.sv
// Self-checking bench for sc_q_update_scheduler. Two scheduler instances
// (DP_LAT=1 and DP_LAT=2) each get their own Q-table RAM and a datapath stub
// that replays a per-request ones-count pattern indexed by cycles since
// sng_load. Expected results come from summing that pattern over the
// evaluation window and saturating.
module tb_sc_q_update_scheduler;

    localparam int N  = 8;
    localparam int L  = 256;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]          req_valid, req_ready, mem_rd_en, mem_wr_en;
    logic [1:0]          sng_load, sng_en, rsp_valid, rsp_ready, busy;
    logic [1:0][AW-1:0]  req_addr, mem_addr, rsp_addr;
    logic [1:0][N-1:0]   req_q_prime, req_reward, alpha_cfg, gamma_cfg;
    logic [1:0][N-1:0]   mem_rd_data, mem_wr_data, rsp_q_new;
    logic [1:0][N-1:0]   sng_q, sng_q_prime, sng_reward, sng_alpha, sng_gamma;
    logic [1:0][1:0]     dp_out;

    logic [1:0]          bd_we;
    logic [AW-1:0]       bd_addr;
    logic [N-1:0]        bd_data;

    logic [1:0]          dpv [2][512];
    logic [1:0]          dp_idle [2];
    logic [N-1:0]        ref_ram [2][64];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [N-1:0] ram [64];
        logic [N-1:0] rd_q;
        int           t = 100000;

        sc_q_update_scheduler #(
            .N(N), .BITSTREAM_LENGTH(L), .ADDR_W(AW), .DP_LAT(g + 1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_addr    (req_addr[g]),
            .req_q_prime (req_q_prime[g]),
            .req_reward  (req_reward[g]),
            .alpha_cfg   (alpha_cfg[g]),
            .gamma_cfg   (gamma_cfg[g]),
            .mem_rd_en   (mem_rd_en[g]),
            .mem_wr_en   (mem_wr_en[g]),
            .mem_addr    (mem_addr[g]),
            .mem_rd_data (mem_rd_data[g]),
            .mem_wr_data (mem_wr_data[g]),
            .sng_load    (sng_load[g]),
            .sng_en      (sng_en[g]),
            .sng_q       (sng_q[g]),
            .sng_q_prime (sng_q_prime[g]),
            .sng_reward  (sng_reward[g]),
            .sng_alpha   (sng_alpha[g]),
            .sng_gamma   (sng_gamma[g]),
            .dp_out      (dp_out[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_addr    (rsp_addr[g]),
            .rsp_q_new   (rsp_q_new[g]),
            .busy        (busy[g])
        );

        // Synchronous-read Q-table with a bench backdoor write port.
        always @(posedge clk) begin
            if (bd_we[g])           ram[bd_addr] <= bd_data;
            else if (mem_wr_en[g])  ram[mem_addr[g]] <= mem_wr_data[g];
            if (mem_rd_en[g])       rd_q <= ram[mem_addr[g]];
        end

        // Datapath stub: t = 0 in the first cycle after sng_load.
        always @(posedge clk) begin
            if (sng_load[g])      t <= 0;
            else if (t < 100000)  t <= t + 1;
        end

        assign mem_rd_data[g] = rd_q;
        assign dp_out[g]      = (t < L + 16) ? dpv[g][t[8:0]] : dp_idle[g];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dpl(input int l);
        return l + 1;
    endfunction

    // Reference result: ones-counts inside the window, saturated to N bits.
    function automatic int window_sum(input int l);
        int s = 0;
        for (int k = dpl(l); k < dpl(l) + L; k++) s += int'(dpv[l][k]);
        return (s > 255) ? 255 : s;
    endfunction

    // mode 0: 1 on odd cycles; 1: all 3; 2: 3 outside window, 0 inside;
    // 3: random; 4: exactly 100 ones at the start of the window.
    task automatic set_pattern(input int l, input int mode);
        for (int k = 0; k < 512; k++) begin
            case (mode)
                0: dpv[l][k] = 2'(k % 2);
                1: dpv[l][k] = 2'd3;
                2: dpv[l][k] = (k >= dpl(l) && k < dpl(l) + L) ? 2'd0 : 2'd3;
                3: dpv[l][k] = 2'($urandom_range(0, 3));
                default: dpv[l][k] = (k >= dpl(l) && k < dpl(l) + 100) ? 2'd1 : 2'd0;
            endcase
        end
        dp_idle[l] = (mode == 2) ? 2'd3 : 2'($urandom_range(0, 3));
    endtask

    task automatic bd_write(input logic [1:0] lanes, input logic [AW-1:0] a, input logic [N-1:0] d);
        bd_we = lanes; bd_addr = a; bd_data = d;
        @(posedge clk); @(negedge clk);
        bd_we = '0;
        for (int l = 0; l < 2; l++) if (lanes[l]) ref_ram[l][a] = d;
    endtask

    task automatic check_reset_state(input int l);
        check("rst_ctrl", {req_ready[l], busy[l], mem_rd_en[l], mem_wr_en[l],
                           sng_load[l], sng_en[l], rsp_valid[l]}, 7'b1000000);
        check("rst_data", {mem_addr[l], mem_wr_data[l], sng_q[l], sng_q_prime[l],
                           sng_reward[l], sng_alpha[l], sng_gamma[l]} == '0 &&
                          {rsp_addr[l], rsp_q_new[l]} == '0, 1);
    endtask

    // Issue one request (caller is at a negedge) and follow it to the response.
    task automatic run_update(input int l, input logic [AW-1:0] addr,
                              input logic [N-1:0] qp, input logic [N-1:0] rw,
                              input logic [N-1:0] al, input logic [N-1:0] gm,
                              input int hold, input bit keep_valid);
        int exp_new, exp_q, cyc, w, viol, stab;
        int rd_cnt, wr_cnt, ld_cnt, en_cnt, first_en, rd_cyc, ld_cyc, wr_cyc;
        logic [AW-1:0] rd_a, wr_a;
        logic [N-1:0]  wr_d;
        logic [5*N-1:0] ops;
        exp_q   = int'(ref_ram[l][addr]);
        exp_new = window_sum(l);
        req_addr[l] = addr; req_q_prime[l] = qp; req_reward[l] = rw;
        alpha_cfg[l] = al; gamma_cfg[l] = gm; req_valid[l] = 1'b1;
        w = 0;
        while (!req_ready[l] && w < 50) begin @(negedge clk); w++; end
        check("req_ready", req_ready[l], 1);
        @(posedge clk); @(negedge clk);
        req_valid[l] = 1'b0;
        req_addr[l] = AW'($urandom); req_q_prime[l] = N'($urandom);
        req_reward[l] = N'($urandom); alpha_cfg[l] = N'($urandom); gamma_cfg[l] = N'($urandom);
        cyc = 1; viol = 0; rd_cnt = 0; wr_cnt = 0; ld_cnt = 0; en_cnt = 0;
        first_en = -1; rd_cyc = -1; ld_cyc = -1; wr_cyc = -1;
        rd_a = '0; wr_a = '0; wr_d = '0; ops = '0;
        while (!rsp_valid[l] && cyc < L + dpl(l) + 20) begin
            if (mem_rd_en[l] && mem_wr_en[l]) viol++;
            if (sng_load[l] && sng_en[l])     viol++;
            if (!busy[l])                     viol++;
            if (mem_rd_en[l]) begin rd_cnt++; rd_cyc = cyc; rd_a = mem_addr[l]; end
            if (sng_load[l]) begin
                ld_cnt++; ld_cyc = cyc;
                ops = {sng_q[l], sng_q_prime[l], sng_reward[l], sng_alpha[l], sng_gamma[l]};
            end
            if (sng_en[l]) begin en_cnt++; if (first_en < 0) first_en = cyc; end
            if (mem_wr_en[l]) begin wr_cnt++; wr_cyc = cyc; wr_a = mem_addr[l]; wr_d = mem_wr_data[l]; end
            @(negedge clk); cyc++;
        end
        check("rd_cycle", rd_cyc, 1);
        check("rd_addr", rd_a, addr);
        check("load_cycle", ld_cyc, 3);
        check("sng_q", ops[5*N-1 -: N], exp_q);
        check("sng_ops", ops[4*N-1:0], {qp, rw, al, gm});
        check("sng_en_first", first_en, 4);
        check("sng_en_count", en_cnt, L);
        check("strobe_counts", {rd_cnt[7:0], wr_cnt[7:0], ld_cnt[7:0]}, 24'h010101);
        check("wr_cycle", wr_cyc, L + dpl(l) + 4);
        check("wr_addr", wr_a, addr);
        check("wr_data", wr_d, exp_new);
        check("exclusive_busy", viol, 0);
        check("rsp_cycle", cyc, L + dpl(l) + 5);
        check("rsp_addr", rsp_addr[l], addr);
        check("rsp_q_new", rsp_q_new[l], exp_new);
        ref_ram[l][addr] = N'(exp_new);
        if (keep_valid) begin
            req_addr[l] = addr; req_q_prime[l] = qp; req_reward[l] = rw;
            alpha_cfg[l] = al; gamma_cfg[l] = gm; req_valid[l] = 1'b1;
        end
        stab = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid[l] !== 1'b1 || rsp_addr[l] !== addr ||
                rsp_q_new[l] !== N'(exp_new) || req_ready[l] !== 1'b0) stab++;
        end
        if (hold > 0) check("hold_stable", stab, 0);
        rsp_ready[l] = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready[l] = 1'b0;
        check("rsp_done", {rsp_valid[l], req_ready[l]}, 2'b01);
    endtask

    // Start an update, then reset at RUN cycle 50 and check the abort.
    task automatic reset_abort(input int l, input logic [AW-1:0] addr);
        int cyc, bad;
        set_pattern(l, 1);
        req_addr[l] = addr; req_q_prime[l] = N'($urandom); req_reward[l] = N'($urandom);
        alpha_cfg[l] = N'($urandom); gamma_cfg[l] = N'($urandom); req_valid[l] = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid[l] = 1'b0;
        cyc = 1; bad = 0;
        while (cyc < 4 + 50) begin
            if (mem_wr_en[l] || rsp_valid[l]) bad++;
            @(negedge clk); cyc++;
        end
        check("abort_in_run", sng_en[l], 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check_reset_state(l);
        for (int i = 0; i < L + 20; i++) begin
            if (mem_wr_en[l] || rsp_valid[l]) bad++;
            @(negedge clk);
        end
        check("abort_no_wr_rsp", bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; rsp_ready = '0; bd_we = '0; bd_addr = '0; bd_data = '0;
        req_addr = '0; req_q_prime = '0; req_reward = '0; alpha_cfg = '0; gamma_cfg = '0;
        set_pattern(0, 0);
        set_pattern(1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);

        for (int a = 0; a < 64; a++) bd_write(2'b11, AW'(a), N'($urandom));
        bd_write(2'b11, 6'd5, 8'h40);

        // Alternate ones -> 128.
        set_pattern(0, 0);
        run_update(0, 6'd5, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0, 0);
        // Saturation.
        set_pattern(0, 1);
        run_update(0, 6'd17, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0, 0);
        // Window alignment on the DP_LAT=2 instance.
        set_pattern(1, 2);
        run_update(1, 6'd33, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0, 0);
        // Response back-pressure with a pending request, then the same request.
        set_pattern(0, 3);
        run_update(0, 6'd12, 8'h11, 8'h22, 8'h33, 8'h44, 20, 1);
        set_pattern(0, 3);
        run_update(0, 6'd12, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0);
        // Back-to-back to addr 9: first writes 100, second must read it.
        set_pattern(0, 4);
        run_update(0, 6'd9, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0, 0);
        set_pattern(0, 3);
        run_update(0, 6'd9, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0, 0);
        // Reset abort, then a fresh update.
        reset_abort(0, 6'd21);
        set_pattern(0, 3);
        run_update(0, 6'd21, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0, 0);
        // Random traffic on both instances.
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 2; l++) begin
                set_pattern(l, 3);
                run_update(l, AW'($urandom), N'($urandom), N'($urandom), N'($urandom),
                           N'($urandom), int'($urandom_range(0, 3)), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_q_update_scheduler.md
Name: sc_q_update_scheduler

Overview:
- Sequences one stochastic Q-value update per request around the external SC Q-update datapath (SNGs plus XOR/AND product network with 2-bit per-cycle ones-count output).
- Per request: reads Q(addr) from the Q-table, loads SNG operands, runs a BITSTREAM_LENGTH-cycle evaluation window, and accumulates the datapath ones-count.
- Writes the saturated result back to the Q-table and returns it over a valid/ready response channel.
- Sits between the RL agent request logic and the Q-table RAM/SC datapath.

Parameters:
N, 8, operand/Q-value width in bits
BITSTREAM_LENGTH, 256, evaluation window in cycles; must equal 2**N (elaboration-time check, fatal otherwise)
ADDR_W, 6, Q-table address width
DP_LAT, 1, datapath latency in cycles from sng_en to the matching dp_out; range 0..7

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  update request valid
req_ready  out  1  scheduler can accept a request
req_addr  in  ADDR_W  Q-table entry (state,action) to update
req_q_prime  in  N  max Q of next state
req_reward  in  N  reward value
alpha_cfg  in  N  learning rate, sampled on accept
gamma_cfg  in  N  discount, sampled on accept
mem_rd_en  out  1  Q-table read strobe; synchronous RAM, data valid next cycle
mem_wr_en  out  1  Q-table write strobe
mem_addr  out  ADDR_W  Q-table address for read and write
mem_rd_data  in  N  Q-table read data
mem_wr_data  out  N  Q-table write data
sng_load  out  1  one-cycle pulse: SNGs latch operands and reseed
sng_en  out  1  SNGs and datapath advance one bit
sng_q, sng_q_prime, sng_reward, sng_alpha, sng_gamma  out  N each  SNG operand values, held stable from LOAD until next LOAD
dp_out  in  2  datapath ones-count this cycle (0..3)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_addr  out  ADDR_W  address of completed update
rsp_q_new  out  N  updated Q value
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sync, active-high; dominates all other inputs):
  - state=IDLE.
  - req_ready=1; busy=0.
  - mem_rd_en, mem_wr_en, sng_load, sng_en, rsp_valid = 0.
  - All data outputs and accumulator = 0.
  - Reset mid-operation aborts with no memory write and no response; the SNG operand outputs go to 0.
- FSM: IDLE -> READ -> WAIT -> LOAD -> RUN -> WRITE -> RESP -> IDLE.
- IDLE:
  - req_ready=1 (only in IDLE).
  - On req_valid&&req_ready, capture req_addr, req_q_prime, req_reward, alpha_cfg, gamma_cfg; go to READ.
  - Input changes after accept are ignored.
- READ: mem_rd_en=1 and mem_addr=captured addr for exactly one cycle.
- WAIT: one cycle for RAM latency.
- LOAD:
  - Capture mem_rd_data into sng_q and drive all sng_* operands.
  - sng_load=1 for this cycle only.
  - Clear the accumulator.
- RUN:
  - Internal cycle counter spans BITSTREAM_LENGTH+DP_LAT cycles.
  - sng_en=1 for exactly the first BITSTREAM_LENGTH cycles, then 0.
  - The accumulator adds dp_out only in RUN cycles DP_LAT .. DP_LAT+BITSTREAM_LENGTH-1; dp_out at any other time is ignored.
  - Accumulator width N+2 bits; maximum 3*BITSTREAM_LENGTH, so it never wraps.
- WRITE:
  - mem_wr_en=1 for one cycle; mem_addr=captured addr.
  - mem_wr_data = min(acc, 2**N-1), i.e. saturation.
  - rsp_q_new and rsp_addr are registered with the same values.
- RESP:
  - rsp_valid=1; rsp_addr and rsp_q_new held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE; req_ready=1 the following cycle.
- Latency: with the accept cycle as cycle 0, rsp_valid first rises in cycle BITSTREAM_LENGTH+DP_LAT+5.
- Ordering: the write-back completes before rsp_valid, so a following request to the same addr reads the updated value (no RAW hazard).
- Never asserted together: mem_rd_en and mem_wr_en; sng_load and sng_en.
- busy = (state != IDLE).

Test Plan:
1. Reset, then N=8/L=256/DP_LAT=1; request addr=5, RAM[5]=0x40, dp_out=1 on alternate cycles -> sng_q=0x40 at the sng_load pulse; exactly 256 sng_en cycles; mem_wr_data=128 at addr 5; rsp_valid at cycle 262; rsp_q_new=128.
2. dp_out=3 for the whole window -> acc=768, saturates; mem_wr_data=rsp_q_new=255.
3. dp_out=3 on every cycle outside the window and 0 inside (DP_LAT=2) -> result 0, proving window alignment; sng_en still exactly L cycles.
4. Hold rsp_ready=0 for 20 cycles with req_valid=1 -> rsp_valid/rsp_addr/rsp_q_new stable and req_ready=0 throughout; after the rsp_ready handshake, req_ready=1 next cycle and the new request is accepted.
5. Back-to-back updates to addr 9 (first writes 100) -> the second request's sng_q=100.
6. Assert reset at RUN cycle 50 -> no mem_wr_en, no rsp_valid; outputs at reset values the next cycle; a fresh request then completes normally.
